// File: rtl/hazard_unit.sv
// Hazard/forwarding controller: DEPTH-stage destination scoreboard, per-source
// youngest-writer forward select, load-use stall, redirect flush FSM, perf counters.

module hazard_src #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int FSEL_W   = 2
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic                         used,
  input  logic [DEPTH:1]               sb_v,
  input  logic [DEPTH:1][REG_AW-1:0]   sb_rd,
  input  logic [DEPTH:1]               sb_we,
  input  logic [DEPTH:1]               sb_ld,
  output logic [FSEL_W-1:0]            sel,
  output logic                         load_haz
);
  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    sel      = '0;
    load_haz = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_v[k] && sb_we[k] && (sb_rd[k] == rs) && (rs != '0) && used) begin
        sel      = FSEL_W'(k);
        load_haz = sb_ld[k] && (k <= LOAD_LAT);
      end
    end
  end
endmodule

module hazard_unit #(
  parameter int DEPTH       = 3,
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int KILL_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [REG_AW-1:0]             id_rs1,
  input  logic [REG_AW-1:0]             id_rs2,
  input  logic                          id_rs1_used,
  input  logic                          id_rs2_used,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          id_we,
  input  logic                          id_is_load,
  input  logic                          redirect,
  output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_b,
  output logic                          stall,
  output logic                          flush,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);
  localparam int FSEL_W = $clog2(DEPTH+1);
  localparam logic [3:0] KRELOAD = 4'(KILL_CYCLES-1);

  typedef enum logic {RUN, KILL} state_t;

  logic [DEPTH:1]             sb_v, sb_we, sb_ld;
  logic [DEPTH:1][REG_AW-1:0] sb_rd;
  logic [1:0][REG_AW-1:0]     rs;
  logic [1:0]                 used, haz;
  logic [1:0][FSEL_W-1:0]     sel;
  state_t                     state, state_nx;
  logic [3:0]                 kill_cnt, kill_cnt_nx;

  assign rs   = {id_rs2, id_rs1};
  assign used = {id_rs2_used, id_rs1_used};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      hazard_src #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .FSEL_W(FSEL_W)) u_src (
        .rs(rs[g]), .used(used[g]),
        .sb_v(sb_v), .sb_rd(sb_rd), .sb_we(sb_we), .sb_ld(sb_ld),
        .sel(sel[g]), .load_haz(haz[g])
      );
    end
  endgenerate

  assign fwd_sel_a = sel[0];
  assign fwd_sel_b = sel[1];
  assign stall     = id_valid && !redirect && (|haz);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_v  <= '0;
      sb_we <= '0;
      sb_ld <= '0;
      sb_rd <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_v[k]  <= sb_v[k-1];
        sb_we[k] <= sb_we[k-1];
        sb_ld[k] <= sb_ld[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      sb_v[1]  <= id_valid && !stall && !flush;
      sb_we[1] <= id_we;
      sb_ld[1] <= id_is_load;
      sb_rd[1] <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      kill_cnt <= '0;
    end else begin
      state    <= state_nx;
      kill_cnt <= kill_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    kill_cnt_nx = kill_cnt;
    if (redirect) begin
      kill_cnt_nx = KRELOAD;
      state_nx    = (KRELOAD != '0) ? KILL : RUN;
    end else if (state == KILL) begin
      kill_cnt_nx = (kill_cnt == '0) ? '0 : kill_cnt - 4'd1;
      state_nx    = (kill_cnt <= 4'd1) ? RUN : KILL;
    end
  end

  always_comb begin
    flush = redirect || (state == KILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
